// File: rtl/interboard_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : interboard_tx_sched
// Purpose  : Shares the interboard transmit link between source A (game
//            controller) and source B (system/reset logic). Each source has
//            a small FIFO. The scheduler grants one source and sends its head
//            message to the link sender. It then waits for the link-level
//            acknowledge and re-sends on timeout, up to MAX_RETRY times,
//            before dropping the message and flagging tx_err.
// Config   : TX_RR_EN defined   -> round-robin between A and B
//            TX_RR_EN undefined -> fixed priority, A before B
// Revision : 1.0  initial release
// ============================================================================
module interboard_tx_sched #(
    parameter int DEPTH     = 4,       // power of 2, >= 2
    parameter int TIMEOUT   = 100000,  // >= 2
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_en,
    input  logic [2:0] a_msg_type,
    input  logic [4:0] a_number,
    output logic       a_full,
    input  logic       b_en,
    input  logic [2:0] b_msg_type,
    input  logic [4:0] b_number,
    output logic       b_full,
    input  logic       link_ready,
    input  logic       link_done,
    output logic       link_en,
    output logic [2:0] link_msg_type,
    output logic [4:0] link_number,
    output logic       busy,
    output logic [1:0] overflow,
    output logic       tx_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Per-source views, index 0 = A, index 1 = B
    logic [1:0] w_en;
    logic [7:0] w_data [2];
    logic [7:0] w_head [2];
    logic [1:0] w_empty;
    logic [1:0] w_full;
    logic [1:0] w_ovf;
    logic [1:0] w_pop;

    assign w_en      = {b_en, a_en};
    assign w_data[0] = {a_msg_type, a_number};
    assign w_data[1] = {b_msg_type, b_number};

    // ------------------------------------------------------------------
    // Source FIFOs
    // ------------------------------------------------------------------
    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            logic [7:0]       mem_q [DEPTH];
            logic [7:0]       mem_d [DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             full_q, full_d;
            logic             ovf_q, ovf_d;
            logic             w_wr;
            logic             w_rd;

            // Write when not full (judged on the current count, so a
            // simultaneous pop never rescues a write into a full FIFO).
            always_comb begin
                w_wr     = w_en[s] && (cnt_q != CNT_FULL);
                w_rd     = w_pop[s] && (cnt_q != '0);
                mem_d    = mem_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                if (w_wr) begin
                    mem_d[wr_ptr_q] = w_data[s];
                    wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                end
                if (w_rd) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                case ({w_wr, w_rd})
                    2'b10:   cnt_d = cnt_q + CNT_W'(1);
                    2'b01:   cnt_d = cnt_q - CNT_W'(1);
                    default: cnt_d = cnt_q;
                endcase
                full_d = (cnt_d == CNT_FULL);
                ovf_d  = ovf_q | (w_en[s] && (cnt_q == CNT_FULL));
            end

            // FIFO storage, pointers, count and sticky overflow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                    full_q   <= 1'b0;
                    ovf_q    <= 1'b0;
                end else begin
                    mem_q    <= mem_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                    full_q   <= full_d;
                    ovf_q    <= ovf_d;
                end
            end

            assign w_head[s]  = mem_q[rd_ptr_q];
            assign w_empty[s] = (cnt_q == '0);
            assign w_full[s]  = full_q;
            assign w_ovf[s]   = ovf_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scheduler state and datapath
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [2:0]       type_q, type_d;
    logic [4:0]       num_q, num_d;
    logic             tx_err_q, tx_err_d;
    logic             w_grant_b;
    logic             w_start;
    logic             w_timeout;

`ifdef TX_RR_EN
    logic             last_b_q, last_b_d;   // 1: B got the last grant

    // Round-robin: on a tie the source not granted last time wins
    always_comb begin
        w_grant_b = w_empty[0] | (~w_empty[1] & ~last_b_q);
    end
`else
    // Fixed priority: B only when A has nothing queued
    always_comb begin
        w_grant_b = w_empty[0];
    end
`endif

    // Issue and timeout qualifiers
    always_comb begin
        w_start   = (state_q == ST_IDLE) && link_ready && !(&w_empty);
        w_timeout = (tmo_q == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an acknowledge beats a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (link_done) begin
                    state_d = ST_IDLE;
                end else if (w_timeout) begin
                    state_d = (retry_q == RETRY_MAX) ? ST_IDLE : ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: pop/latch payload, timeout and retry counting
    always_comb begin
        w_pop    = 2'b00;
        type_d   = type_q;
        num_d    = num_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        tx_err_d = tx_err_q;
`ifdef TX_RR_EN
        last_b_d = last_b_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    w_pop  = w_grant_b ? 2'b10 : 2'b01;
                    type_d = w_grant_b ? w_head[1][7:5] : w_head[0][7:5];
                    num_d  = w_grant_b ? w_head[1][4:0] : w_head[0][4:0];
`ifdef TX_RR_EN
                    last_b_d = w_grant_b;
`endif
                end
            end
            ST_ISSUE: begin
                tmo_d = '0;
            end
            ST_WAIT: begin
                if (link_done) begin
                    retry_d = '0;
                end else if (w_timeout) begin
                    if (retry_q == RETRY_MAX) begin
                        tx_err_d = 1'b1;
                        retry_d  = '0;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                tmo_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q    <= '0;
            retry_q  <= '0;
            type_q   <= '0;
            num_q    <= '0;
            tx_err_q <= 1'b0;
`ifdef TX_RR_EN
            last_b_q <= 1'b1;
`endif
        end else begin
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            type_q   <= type_d;
            num_q    <= num_d;
            tx_err_q <= tx_err_d;
`ifdef TX_RR_EN
            last_b_q <= last_b_d;
`endif
        end
    end

    // Output decode
    always_comb begin
        link_en       = (state_q == ST_ISSUE);
        busy          = (state_q != ST_IDLE);
        link_msg_type = type_q;
        link_number   = num_q;
        tx_err        = tx_err_q;
        overflow      = w_ovf;
        a_full        = w_full[0];
        b_full        = w_full[1];
    end

endmodule
`default_nettype wire
